axi4_lite_read_arbiter: RTL and testbench



---
 rtl/axi4_lite_read_arbiter.sv | 158 +++++++++++++++
 tb/tb_axi4_lite_read_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_read_arbiter
//
// Round-robin arbiter that lets several AXI4-Lite read managers share a
// single downstream AR/R channel pair. Only one transaction is in flight at
// a time, and the response goes back to the manager that issued the request.
//
// Ports
//   clk_i        clock
//   rst_clk_ni   synchronous active-low reset
//   m_araddr_i   upstream read addresses, manager k at [k*ADDRESS_SIZE +: ADDRESS_SIZE]
//   m_arvalid_i  upstream address valid, one bit per manager
//   m_arready_o  upstream address ready, high only for the IDLE winner
//   m_rdata_o    read data, broadcast (zero outside the data phase)
//   m_rresp_o    read response, broadcast (zero outside the data phase)
//   m_rvalid_o   read valid, only the granted manager's bit can be high
//   m_rready_i   upstream read ready
//   s_araddr_o   downstream read address (registered)
//   s_arvalid_o  downstream address valid (registered)
//   s_arready_i  downstream address ready
//   s_rdata_i    downstream read data
//   s_rresp_i    downstream read response
//   s_rvalid_i   downstream read valid
//   s_rready_o   downstream read ready, taken from the granted manager
//   grant_o      one-hot owner of the current transaction, zero in IDLE
//   busy_o       high whenever a transaction is in progress
// ---------------------------------------------------------------------------
module axi4_lite_read_arbiter #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int MANAGERS     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_clk_ni,
  input  logic [MANAGERS*ADDRESS_SIZE-1:0] m_araddr_i,
  input  logic [MANAGERS-1:0]              m_arvalid_i,
  output logic [MANAGERS-1:0]              m_arready_o,
  output logic [DATA_SIZE-1:0]             m_rdata_o,
  output logic [1:0]                       m_rresp_o,
  output logic [MANAGERS-1:0]              m_rvalid_o,
  input  logic [MANAGERS-1:0]              m_rready_i,
  output logic [ADDRESS_SIZE-1:0]          s_araddr_o,
  output logic                             s_arvalid_o,
  input  logic                             s_arready_i,
  input  logic [DATA_SIZE-1:0]             s_rdata_i,
  input  logic [1:0]                       s_rresp_i,
  input  logic                             s_rvalid_i,
  output logic                             s_rready_o,
  output logic [MANAGERS-1:0]              grant_o,
  output logic                             busy_o
);

  localparam int IDX_W = (MANAGERS > 1) ? $clog2(MANAGERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [MANAGERS-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [ADDRESS_SIZE-1:0] araddr_q, araddr_d;

  logic [IDX_W-1:0]        cand;
  logic [IDX_W-1:0]        winner;
  logic                    win_found;

  // Index base+offs wrapped into 0..MANAGERS-1; offs never exceeds MANAGERS,
  // so a single subtraction is enough.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= MANAGERS) s = s - MANAGERS;
    return s[IDX_W-1:0];
  endfunction

  // Round-robin search starting just after the previous winner, so the most
  // recently served manager has the lowest priority.
  always_comb begin
    cand      = '0;
    winner    = '0;
    win_found = 1'b0;
    for (int i = 1; i <= MANAGERS; i++) begin
      cand = rr_index(last_q, i);
      if (!win_found && m_arvalid_i[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    araddr_d    = araddr_q;
    m_arready_o = '0;
    m_rvalid_o  = '0;
    m_rdata_o   = '0;
    m_rresp_o   = '0;
    s_rready_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          m_arready_o[winner] = 1'b1;
          araddr_d            = m_araddr_i[int'(winner)*ADDRESS_SIZE +: ADDRESS_SIZE];
          grant_d             = '0;
          grant_d[winner]     = 1'b1;
          last_d              = winner;
          state_d             = ADDR;
        end
      end
      ADDR: begin
        if (s_arready_i) state_d = DATA;
      end
      DATA: begin
        // Response is a pure pass-through gated by the owner's grant bit.
        m_rdata_o  = s_rdata_i;
        m_rresp_o  = s_rresp_i;
        m_rvalid_o = grant_q & {MANAGERS{s_rvalid_i}};
        s_rready_o = |(grant_q & m_rready_i);
        if (s_rvalid_i && s_rready_o) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_clk_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(MANAGERS - 1);
      araddr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      araddr_q <= araddr_d;
    end
  end

  // s_arvalid_o comes straight from the state register, so it cannot glitch
  // and stays high until the downstream handshake moves the FSM on.
  assign s_arvalid_o = (state_q == ADDR);
  assign s_araddr_o  = araddr_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
module tb_axi4_lite_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int M2 = 2;
  localparam int M4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- two-manager instance ----------------
  logic              a_rst_n;
  logic [M2*AW-1:0]  a_araddr;
  logic [M2-1:0]     a_arvalid, a_arready, a_rvalid, a_rready, a_grant;
  logic [DW-1:0]     a_rdata, a_s_rdata;
  logic [1:0]        a_rresp, a_s_rresp;
  logic [AW-1:0]     a_s_araddr;
  logic              a_s_arvalid, a_s_arready, a_s_rvalid, a_s_rready, a_busy;

  axi4_lite_read_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MANAGERS(M2)) dut2 (
    .clk_i(clk), .rst_clk_ni(a_rst_n),
    .m_araddr_i(a_araddr), .m_arvalid_i(a_arvalid), .m_arready_o(a_arready),
    .m_rdata_o(a_rdata), .m_rresp_o(a_rresp), .m_rvalid_o(a_rvalid), .m_rready_i(a_rready),
    .s_araddr_o(a_s_araddr), .s_arvalid_o(a_s_arvalid), .s_arready_i(a_s_arready),
    .s_rdata_i(a_s_rdata), .s_rresp_i(a_s_rresp), .s_rvalid_i(a_s_rvalid), .s_rready_o(a_s_rready),
    .grant_o(a_grant), .busy_o(a_busy)
  );

  // ---------------- four-manager instance ----------------
  logic              b_rst_n;
  logic [M4*AW-1:0]  b_araddr;
  logic [M4-1:0]     b_arvalid, b_arready, b_rvalid, b_rready, b_grant;
  logic [DW-1:0]     b_rdata, b_s_rdata;
  logic [1:0]        b_rresp, b_s_rresp;
  logic [AW-1:0]     b_s_araddr;
  logic              b_s_arvalid, b_s_arready, b_s_rvalid, b_s_rready, b_busy;

  axi4_lite_read_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .MANAGERS(M4)) dut4 (
    .clk_i(clk), .rst_clk_ni(b_rst_n),
    .m_araddr_i(b_araddr), .m_arvalid_i(b_arvalid), .m_arready_o(b_arready),
    .m_rdata_o(b_rdata), .m_rresp_o(b_rresp), .m_rvalid_o(b_rvalid), .m_rready_i(b_rready),
    .s_araddr_o(b_s_araddr), .s_arvalid_o(b_s_arvalid), .s_arready_i(b_s_arready),
    .s_rdata_i(b_s_rdata), .s_rresp_i(b_s_rresp), .s_rvalid_i(b_s_rvalid), .s_rready_o(b_s_rready),
    .grant_o(b_grant), .busy_o(b_busy)
  );

  // ---------------- transaction-level reference model ----------------
  bit            mdl_busy, mdl_addr_ph;
  int            mdl_last, mdl_owner;
  logic [AW-1:0] mdl_cap;

  bit            req[M2];
  logic [AW-1:0] req_addr[M2];
  bit            waiting[M2];
  logic [AW-1:0] own_addr[M2];

  bit            auto_mgr, rr_forced;
  logic [M2-1:0] rr_val;
  int            p_req, p_drop, p_stray;
  bit            nx_rst_n;

  bit            sub_has, rnd_sub, sub_fixed_en;
  logic [AW-1:0] sub_addr;
  logic [DW-1:0] sub_fixed_data;
  int            sub_ar_cnt, sub_r_cnt, ar_wait, r_wait;
  logic [1:0]    sub_resp, dir_resp;

  logic [M2-1:0] ar_log[$];
  int            ar_hi_cycles, rv_hi_cycles, completions;

  function automatic logic [DW-1:0] sub_word(input logic [AW-1:0] a);
    if (sub_fixed_en) return sub_fixed_data;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // First requester after 'last' in circular order, -1 if none.
  function automatic int rr_pick(input int last, input logic [M2-1:0] v);
    for (int i = 1; i <= M2; i++) begin
      int k = (last + i) % M2;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mdl_busy = 0; mdl_addr_ph = 0; mdl_last = M2 - 1; mdl_owner = 0;
    for (int k = 0; k < M2; k++) begin req[k] = 0; waiting[k] = 0; end
    sub_has = 0; sub_ar_cnt = 0; sub_r_cnt = 0;
  endtask

  // One clock of the two-manager environment: drive at negedge, check 1ns
  // later, then advance the model by the handshakes that the next posedge takes.
  task automatic step();
    logic [M2-1:0] exp_ar, exp_rv, exp_gr;
    logic          exp_srr;
    logic [DW-1:0] exp_rd;
    logic [1:0]    exp_rr;
    int            w;
    @(negedge clk);
    a_rst_n = nx_rst_n;
    for (int k = 0; k < M2; k++) begin
      if (auto_mgr && !req[k] && !waiting[k] && ($urandom_range(99) < p_req)) begin
        req[k] = 1; req_addr[k] = $urandom & 32'hFFFF_FFFC;
      end else if (auto_mgr && req[k] && ($urandom_range(99) < p_drop)) begin
        req[k] = 0;
      end
      a_arvalid[k] = req[k];
      a_araddr[k*AW +: AW] = req[k] ? req_addr[k] : $urandom;
      a_rready[k] = rr_forced ? rr_val[k] : ($urandom_range(99) < 70);
    end
    a_s_arready = !sub_has && (sub_ar_cnt >= ar_wait);
    if (sub_has && (sub_r_cnt >= r_wait)) begin
      a_s_rvalid = 1'b1; a_s_rdata = sub_word(sub_addr); a_s_rresp = sub_resp;
    end else begin
      a_s_rvalid = !sub_has && ($urandom_range(99) < p_stray);
      a_s_rdata  = $urandom; a_s_rresp = 2'($urandom);
    end
    #1;
    if (!nx_rst_n) begin
      model_reset();
      return;
    end
    exp_ar = '0; exp_gr = '0; exp_rv = '0; exp_srr = 1'b0; exp_rd = '0; exp_rr = '0;
    if (!mdl_busy) begin
      w = rr_pick(mdl_last, a_arvalid);
      if (w >= 0) exp_ar[w] = 1'b1;
    end else begin
      exp_gr[mdl_owner] = 1'b1;
      if (mdl_addr_ph) check_eq("s_araddr", a_s_araddr, mdl_cap);
      else begin
        exp_rv  = a_s_rvalid ? exp_gr : '0;
        exp_srr = a_rready[mdl_owner];
        exp_rd  = a_s_rdata;
        exp_rr  = a_s_rresp;
      end
    end
    check_eq("m_arready", a_arready, exp_ar);
    check_eq("grant", a_grant, exp_gr);
    check_eq("busy", a_busy, mdl_busy);
    check_eq("s_arvalid", a_s_arvalid, mdl_busy && mdl_addr_ph);
    check_eq("m_rvalid", a_rvalid, exp_rv);
    check_eq("s_rready", a_s_rready, exp_srr);
    check_eq("m_rdata", a_rdata, exp_rd);
    check_eq("m_rresp", a_rresp, exp_rr);
    if (a_arready != '0) ar_log.push_back(a_arready);
    if (a_s_arvalid) ar_hi_cycles++;
    if (a_rvalid != '0) rv_hi_cycles++;
    if (!mdl_busy) begin
      w = rr_pick(mdl_last, a_arvalid);
      if (w >= 0) begin
        mdl_busy = 1; mdl_addr_ph = 1; mdl_owner = w; mdl_last = w;
        mdl_cap = req_addr[w]; own_addr[w] = req_addr[w];
        req[w] = 0; waiting[w] = 1;
      end
    end else if (mdl_addr_ph) begin
      if (a_s_arready) begin
        mdl_addr_ph = 0; sub_has = 1; sub_addr = a_s_araddr;
        sub_ar_cnt = 0; sub_r_cnt = 0;
        sub_resp = rnd_sub ? 2'($urandom) : dir_resp;
        if (rnd_sub) r_wait = $urandom_range(3);
      end else sub_ar_cnt++;
    end else begin
      if (a_s_rvalid && a_rready[mdl_owner]) begin
        check_eq("e2e_rdata", a_rdata, sub_word(own_addr[mdl_owner]));
        check_eq("e2e_rresp", a_rresp, sub_resp);
        mdl_busy = 0; waiting[mdl_owner] = 0; sub_has = 0; completions++;
        if (rnd_sub) ar_wait = $urandom_range(3);
      end else sub_r_cnt++;
    end
  endtask

  task automatic wait_rvalid(input string tag);
    for (int i = 0; i < 20 && a_rvalid == '0; i++) step();
    check_eq(tag, |a_rvalid, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < M2; k++) req[k] = 0;
    rr_forced = 1; rr_val = '1;
    for (int i = 0; i < 20 && (mdl_busy || a_busy); i++) step();
    check_eq("drain_idle", a_busy, 1'b0);
  endtask

  task automatic do_reset();
    nx_rst_n = 0; step(); step();
    nx_rst_n = 1;
  endtask

  initial begin
    a_rst_n = 0; a_araddr = '0; a_arvalid = '0; a_rready = '0;
    a_s_arready = 0; a_s_rdata = '0; a_s_rresp = '0; a_s_rvalid = 0;
    b_rst_n = 0; b_araddr = '0; b_arvalid = '0; b_rready = '0;
    b_s_arready = 0; b_s_rdata = '0; b_s_rresp = '0; b_s_rvalid = 0;
    auto_mgr = 0; rr_forced = 1; rr_val = '1; p_req = 0; p_drop = 0; p_stray = 0;
    rnd_sub = 0; sub_fixed_en = 0; sub_fixed_data = '0; ar_wait = 0; r_wait = 0;
    dir_resp = 2'b00; sub_resp = 2'b00; nx_rst_n = 0; completions = 0;
    ar_hi_cycles = 0; rv_hi_cycles = 0;
    model_reset();

    // ---- four managers: only manager 3 requests, stray rvalid in IDLE ----
    @(negedge clk); b_rst_n = 0;
    @(negedge clk); b_rst_n = 1; #1;
    check_eq("m4_reset_busy", {b_busy, b_grant, b_arready, b_rvalid}, '0);
    @(negedge clk); b_s_rvalid = 1; b_s_rdata = 32'h1234_5678; b_s_rresp = 2'b11; b_rready = '1; #1;
    check_eq("m4_stray_rvalid", b_rvalid, 4'b0000);
    check_eq("m4_stray_rdata", {b_rdata, b_rresp, b_s_rready, b_busy}, '0);
    @(negedge clk); b_s_rvalid = 0; b_arvalid = 4'b1000; b_araddr[3*AW +: AW] = 32'h30; b_s_arready = 1; #1;
    check_eq("m4_arready", b_arready, 4'b1000);
    @(negedge clk); b_arvalid = '0; #1;
    check_eq("m4_grant", b_grant, 4'b1000);
    check_eq("m4_s_ar", {b_s_arvalid, b_s_araddr}, {1'b1, 32'h30});
    @(negedge clk); b_s_rvalid = 1; b_s_rdata = 32'hCAFE_F00D; b_s_rresp = 2'b01; #1;
    check_eq("m4_rvalid", b_rvalid, 4'b1000);
    check_eq("m4_rdata", {b_rdata, b_rresp}, {32'hCAFE_F00D, 2'b01});
    @(negedge clk); b_s_rvalid = 0; #1;
    check_eq("m4_done", {b_busy, b_grant}, '0);

    // ---- two managers: reset then idle ----
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("idle_outputs", {a_arready, a_rvalid, a_s_arvalid, a_s_rready, a_grant, a_busy,
                                a_rdata, a_rresp, a_s_araddr}, '0);
    end

    // ---- single request, zero-wait downstream ----
    sub_fixed_en = 1; sub_fixed_data = 32'hDEAD_BEEF;
    req[0] = 1; req_addr[0] = 32'h8;
    step(); check_eq("single_arready_T", a_arready, 2'b01);
    step(); check_eq("single_s_ar_T1", {a_s_arvalid, a_s_araddr}, {1'b1, 32'h8});
    step(); check_eq("single_r_T2", {a_rvalid, a_rdata}, {2'b01, 32'hDEAD_BEEF});
    step(); check_eq("single_busy_T3", a_busy, 1'b0);
    sub_fixed_en = 0;

    // ---- contention: both managers request continuously ----
    do_reset();
    ar_log.delete();
    auto_mgr = 1; p_req = 100; p_drop = 0;
    req_addr[0] = 32'h0; req_addr[1] = 32'h4;
    for (int i = 0; i < 40 && ar_log.size() < 4; i++) step();
    check_eq("contend_count", ar_log.size(), 4);
    if (ar_log.size() >= 4) begin
      check_eq("contend_g0", ar_log[0], 2'b01);
      check_eq("contend_g1", ar_log[1], 2'b10);
      check_eq("contend_g2", ar_log[2], 2'b01);
      check_eq("contend_g3", ar_log[3], 2'b10);
    end
    auto_mgr = 0;
    drain();

    // ---- downstream arready stall ----
    ar_wait = 3; ar_hi_cycles = 0;
    req[1] = 1; req_addr[1] = 32'h44;
    for (int i = 0; i < 12; i++) step();
    check_eq("ar_stall_cycles", ar_hi_cycles, 4);
    ar_wait = 0;
    drain();

    // ---- upstream rready stall with error response ----
    dir_resp = 2'b10; rr_forced = 1; rr_val = 2'b00; rv_hi_cycles = 0;
    req[0] = 1; req_addr[0] = 32'h10;
    wait_rvalid("r_stall_start");
    step();
    check_eq("r_stall_hold", {a_s_rready, a_busy, a_rvalid}, {1'b0, 1'b1, 2'b01});
    check_eq("r_stall_resp", a_rresp, 2'b10);
    rr_val = 2'b11;
    step(); step();
    check_eq("r_stall_done", a_busy, 1'b0);
    check_eq("r_stall_cycles", rv_hi_cycles, 3);
    dir_resp = 2'b00;

    // ---- reset during DATA with rvalid high ----
    rr_val = 2'b00;
    req[0] = 1; req_addr[0] = 32'h20;
    wait_rvalid("rst_data_phase");
    nx_rst_n = 0; step();
    nx_rst_n = 1; rr_val = 2'b11; step();
    check_eq("rst_outputs", {a_arready, a_rvalid, a_s_arvalid, a_s_rready, a_grant, a_busy,
                             a_rdata, a_rresp, a_s_araddr}, '0);
    req[0] = 1; req_addr[0] = 32'h100; req[1] = 1; req_addr[1] = 32'h104;
    step();
    check_eq("rst_rr_prio", a_arready, 2'b01);
    drain();

    // ---- randomized traffic ----
    auto_mgr = 1; rr_forced = 0; p_req = 40; p_drop = 3; p_stray = 20; rnd_sub = 1;
    completions = 0;
    for (int i = 0; i < 3000; i++) begin
      nx_rst_n = ($urandom_range(999) != 0);
      step();
    end
    nx_rst_n = 1;
    check_eq("rand_progress", completions > 100, 1'b1);
    auto_mgr = 0; p_stray = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
